// File: rtl/lfsr_index_decoder.sv
// Recovers the step index of a 4-bit Fibonacci LFSR state by stepping a local LFSR from the seed
// until it matches; also reports the shift magnitude 15 - index.
module lfsr_index_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] state_in,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] index_out,
   output logic [3:0] shift_mag_out
);

   localparam logic [3:0] Seed     = 4'b0001;
   localparam logic [3:0] LastIdx  = 4'd14;
   localparam logic [3:0] ErrIndex = 4'hF;

   typedef enum logic [0:0] {StIdle, StSearch} state_e;

   state_e     state_q, state_d;
   logic [3:0] target_q, target_d;
   logic [3:0] cand_q, cand_d;
   logic [3:0] count_q, count_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic [3:0] index_q, index_d;

   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cand_d   = cand_q;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      error_d  = error_q;
      index_d  = index_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               target_d = state_in;
               cand_d   = Seed;
               count_d  = 4'd0;
               busy_d   = 1'b1;
               state_d  = StSearch;
            end
         end
         StSearch: begin
            // All-zero target is the lock-up state and never appears; the count guard is a
            // backstop that can only fire on that path.
            if (target_q == 4'b0000 || (cand_q != target_q && count_q == LastIdx)) begin
               error_d = 1'b1;
               index_d = ErrIndex;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (cand_q == target_q) begin
               error_d = 1'b0;
               index_d = count_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               cand_d  = lfsr_next(cand_q);
               count_d = count_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         target_q <= 4'b0000;
         cand_q   <= Seed;
         count_q  <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         index_q  <= 4'h0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cand_q   <= cand_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         index_q  <= index_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign index_out     = index_q;
   assign shift_mag_out = 4'hF - index_q;

endmodule

// File: tb/tb_lfsr_index_decoder.sv
// Scoreboard bench for lfsr_index_decoder: expected index/error/latency are queued at launch and
// compared when done appears.
module tb_lfsr_index_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] state_in = 4'h0;
   logic       busy, done, error;
   logic [3:0] index_out, shift_mag_out;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] idx;
      logic       err;
      logic [4:0] lat;
   } exp_t;

   exp_t sb_q[$];
   logic [3:0] seq_tbl [15];

   lfsr_index_decoder dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .state_in      (state_in),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .index_out     (index_out),
      .shift_mag_out (shift_mag_out)
   );

   always #5 clk = ~clk;

   function automatic exp_t expect_for(input logic [3:0] s);
      exp_t e;
      e.idx = 4'hF;
      e.err = 1'b1;
      e.lat = 5'd1;
      for (int i = 0; i < 15; i++) begin
         if (seq_tbl[i] == s) begin
            e.idx = 4'(i);
            e.err = 1'b0;
            e.lat = 5'(i + 1);
         end
      end
      return e;
   endfunction

   // Drives start for the edge E0 and pushes the expected result.
   task automatic launch(input logic [3:0] s);
      start    = 1'b1;
      state_in = s;
      sb_q.push_back(expect_for(s));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after E0 until done is seen; lat starts from lat0.
   task automatic wait_done(input int lat0, output int lat, output bit ok);
      lat = lat0;
      ok  = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done, error} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got busy/done/error=%b want 000", {busy, done, error});
      end
      checks++;
      if (index_out !== 4'h0 || shift_mag_out !== 4'hF) begin
         errors++;
         $display("FAIL reset_outs got idx=%h mag=%h want idx=0 mag=f", index_out, shift_mag_out);
      end
   endtask

   task automatic test_single(input logic [3:0] s);
      int lat;
      bit ok;
      exp_t e;
      launch(s);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start[%b] got %b want 1", s, busy);
      end
      wait_done(0, lat, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout[%b] got no done want done", s);
      end else begin
         checks++;
         if (lat !== int'(e.lat)) begin
            errors++;
            $display("FAIL latency[%b] got %0d want %0d", s, lat, e.lat);
         end
         checks++;
         if (index_out !== e.idx || error !== e.err || busy !== 1'b0) begin
            errors++;
            $display("FAIL result[%b] got idx=%h err=%b busy=%b want idx=%h err=%b busy=0",
                     s, index_out, error, busy, e.idx, e.err);
         end
         checks++;
         if (shift_mag_out !== 4'hF - e.idx) begin
            errors++;
            $display("FAIL shift_mag[%b] got %h want %h", s, shift_mag_out, 4'hF - e.idx);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      bit ok;
      exp_t e;
      for (int i = 0; i < 15; i++) begin
         launch(seq_tbl[i]);
         if (i != 0) begin
            checks++;
            if (done !== 1'b0) begin
               errors++;
               $display("FAIL done_width[%0d] got done=1 want 0", i);
            end
         end
         wait_done(0, lat, ok);
         e = sb_q.pop_front();
         checks++;
         if (!ok || lat !== int'(e.lat) || index_out !== e.idx || error !== e.err ||
             shift_mag_out !== 4'hF - e.idx) begin
            errors++;
            $display("FAIL sweep[%0d] got ok=%b lat=%0d idx=%h err=%b mag=%h want lat=%0d idx=%h err=%b mag=%h",
                     i, ok, lat, index_out, error, shift_mag_out, e.lat, e.idx, e.err,
                     4'hF - e.idx);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width_last got done=1 want 0");
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      bit ok;
      exp_t e;
      launch(4'b1111);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      start    = 1'b1;
      state_in = 4'b0001;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(4, lat, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || lat !== int'(e.lat) || index_out !== e.idx || error !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start got ok=%b lat=%0d idx=%h err=%b want lat=12 idx=b err=0",
                  ok, lat, index_out, error);
      end
   endtask

   task automatic test_reset_abort;
      int seen;
      launch(4'b1000);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      void'(sb_q.pop_front());
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({busy, done, error} !== 3'b000 || index_out !== 4'h0 || shift_mag_out !== 4'hF) begin
         errors++;
         $display("FAIL abort_reset got busy=%b done=%b err=%b idx=%h mag=%h want 0 0 0 0 f",
                  busy, done, error, index_out, shift_mag_out);
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d done pulses want 0", seen);
      end
      test_single(4'b0100);
   endtask

   initial begin
      seq_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                  4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      test_reset();
      test_single(4'b0001);
      test_single(4'b1000);
      test_single(4'b1010);
      test_back_to_back();
      test_single(4'b0000);
      test_single(4'b0010);
      test_ignore_start();
      test_reset_abort();
      test_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_index_decoder.md
# lfsr_index_decoder

Sequential inverse of the LFSR position encoding: given a 4-bit LFSR state, the block finds that state's step index X, meaning the number of LFSR steps from the seed. It does this by running a local copy of the LFSR from the seed until the copy matches the input. It outputs X and the associated shift magnitude (15 − X) that the associative-memory datapath consumes. It sits between the LFSR-encoded memory tags and the shift-magnitude logic, recovering indices from stored states.

## Interface
Parameters:
- None. LFSR width (4), polynomial and seed are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when busy=0
- state_in  input  4  LFSR state to decode; sampled with start
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse when the result is valid
- error  output  1  high with done when the state is not in the sequence; held until next done
- index_out  output  4  decoded step index 0–14; 4'hF on error; held until next done
- shift_mag_out  output  4  combinational 4'b1111 − index_out (modulo 16)

## Operation
- LFSR definition (Fibonacci form):
  - next = {q[2:0], q[3]^q[2]}
  - seed 4'b0001 is index 0.
- Full index sequence 0–14:
  - 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010,
  - 0101, 1011, 0111, 1111, 1110, 1100, 1000
- State 0000 is not in the sequence and is the only invalid input.
- FSM states: IDLE, SEARCH.
- IDLE:
  - If start=1: latch target<=state_in, cand<=4'b0001, count<=0, busy<=1, go to SEARCH.
  - Otherwise remain in IDLE.
- SEARCH, each cycle, in priority order:
  - target==0000: error<=1, index_out<=4'hF, done<=1, busy<=0, go to IDLE.
  - cand==target: error<=0, index_out<=count, done<=1, busy<=0, go to IDLE.
  - count==14 (guard; unreachable for valid input): treat as error, same outputs as the 0000 case.
  - Otherwise: cand<=next(cand), count<=count+1.
- count is 4 bits and never exceeds 14, so there is no wrap.
- done is cleared on every cycle in which it is not explicitly set, so it is exactly one cycle wide.
- start while busy=1 is ignored, and the latched target is not disturbed.
- start in the same cycle that done is asserted is accepted: the FSM is already in IDLE, so back-to-back requests are allowed.
- rst at any time, including mid-SEARCH:
  - FSM returns to IDLE.
  - No done pulse is generated for the aborted request.
- Reset values:
  - busy=0, done=0, error=0, index_out=4'h0, therefore shift_mag_out=4'hF.
  - Internal target/cand/count are don't-care but are reset to 0 / 0001 / 0.

## Timing
- Edge E0 samples start=1: busy=1 after E0.
- Edge E(n+1), n≥0, evaluates the candidate with count=n.
- Input at index k: done, index_out=k and busy=0 become visible after edge E(k+1). Latency is k+1 cycles: minimum 1 (state 0001), maximum 15 (state 1000).
- Input 0000: done=1, error=1 after E1 (latency 1).
- shift_mag_out follows index_out combinationally, with the same cycle of validity.
- Throughput: a new start may be sampled at the edge following the done edge, or on the done cycle itself (see Operation).

## Test plan
- Reset check: rst=1 for 2 cycles, then 0 → busy=0, done=0, error=0, index_out=0, shift_mag_out=4'hF.
- Seed and far end:
  - start with state_in=0001 → done after exactly 1 cycle, index_out=0, shift_mag_out=15, error=0.
  - state_in=1000 → done after 15 cycles, index_out=14, shift_mag_out=1.
- Mid sequence: state_in=1010 → done after 8 cycles, index_out=7, shift_mag_out=8.
- Exhaustive sweep: all 15 valid states issued back-to-back, each start on its done cycle → every index correct, shift_mag_out = 15 − index, done exactly one cycle each.
- Invalid input: state_in=0000 → done and error after 1 cycle, index_out=4'hF, shift_mag_out=0.
  - Following start with 0010 → error clears, index_out=1.
- Interference:
  - start with 1111 (index 11); pulse start with 0001 at cycle 4 → ignored, result index_out=11 after 12 cycles.
  - Separate run: assert rst at cycle 5 of a 1000 search → no done pulse, outputs at reset values, next start with 0100 → index_out=2.
